// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared types for the RISC-V front end
// Next-PC select modes and PC generator states.
`ifndef REG_SIZE
`define REG_SIZE 32
`endif

package riscv_pkg;

  typedef enum logic [1:0] {
    PC_4    = 2'd0,
    PC_BEQ  = 2'd1,
    PC_J    = 2'd2,
    PC_JALR = 2'd3
  } pc_sel_e;

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    RUN     = 2'd1,
    TRAPPED = 2'd2
  } pcgen_state_e;

endpackage

// File: rtl/pc_target_calc.sv
// rtl/pc_target_calc.sv - combinational next-PC target, sequential PC and misalign detect
// A redirect is any jump or a taken branch; misalign is only flagged for redirects.
module pc_target_calc
  import riscv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int IALIGN = 4
) (
  input  logic [XLEN-1:0] i_pc,
  input  pc_sel_e         i_pc_sel,
  input  logic            i_branch_taken,
  input  logic [XLEN-1:0] i_imm32,
  input  logic [XLEN-1:0] i_rs1_val,
  output logic [XLEN-1:0] o_target,
  output logic [XLEN-1:0] o_seq,
  output logic            o_redirect,
  output logic            o_misaligned
);

  logic [XLEN-1:0] w_rel;
  logic [XLEN-1:0] w_jalr_sum;
  logic            w_bad_align;

  assign o_seq      = i_pc + XLEN'(4);
  assign w_rel      = i_pc + i_imm32;
  assign w_jalr_sum = i_rs1_val + i_imm32;

  always_comb begin
    o_target   = o_seq;
    o_redirect = 1'b0;
    case (i_pc_sel)
      PC_BEQ: begin
        if (i_branch_taken) begin
          o_target   = w_rel;
          o_redirect = 1'b1;
        end
      end
      PC_J: begin
        o_target   = w_rel;
        o_redirect = 1'b1;
      end
      PC_JALR: begin
        o_target   = {w_jalr_sum[XLEN-1:1], 1'b0};
        o_redirect = 1'b1;
      end
      default: begin
        o_target   = o_seq;
        o_redirect = 1'b0;
      end
    endcase
  end

  // With 2-byte alignment the cleared JALR bit 0 can never trip this.
  assign w_bad_align  = (IALIGN == 4) ? (|o_target[1:0]) : o_target[0];
  assign o_misaligned = o_redirect & w_bad_align;

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - program counter generator with fetch handshake and redirect buffer
// Holds the PC register, the BOOT/RUN/TRAPPED FSM and a single-entry pending redirect.
module pc_gen
  import riscv_pkg::*;
#(
  parameter int                 XLEN      = `REG_SIZE,
  parameter logic [XLEN-1:0]    RESET_VEC = 'h0000_0000,
  parameter logic [XLEN-1:0]    TRAP_VEC  = 'h0000_0100,
  parameter int                 IALIGN    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  pc_sel_e         pc_sel,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] imm32,
  input  logic [XLEN-1:0] rs1_val,
  input  logic            stall,
  input  logic            trap,
  input  logic            imem_gnt,
  output logic            imem_req,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus4,
  output logic            misalign_exc,
  output logic            redir_pending
);

  pcgen_state_e    r_state, w_state_nxt;
  logic [XLEN-1:0] r_pc, w_pc_nxt;
  logic [XLEN-1:0] r_pend, w_pend_nxt;
  logic            r_pend_vld, w_pend_vld_nxt;
  logic            r_misalign, w_misalign_nxt;

  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_seq;
  logic            w_redirect;
  logic            w_misaligned;
  logic            w_advance;

  pc_target_calc #(
    .XLEN   (XLEN),
    .IALIGN (IALIGN)
  ) u_calc (
    .i_pc           (r_pc),
    .i_pc_sel       (pc_sel),
    .i_branch_taken (branch_taken),
    .i_imm32        (imm32),
    .i_rs1_val      (rs1_val),
    .o_target       (w_target),
    .o_seq          (w_seq),
    .o_redirect     (w_redirect),
    .o_misaligned   (w_misaligned)
  );

  assign w_advance = (r_state == RUN) & imem_gnt & ~stall;

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_pend_nxt     = r_pend;
    w_pend_vld_nxt = r_pend_vld;
    w_misalign_nxt = 1'b0;
    case (r_state)
      BOOT, TRAPPED: begin
        if (trap) begin
          w_pc_nxt       = TRAP_VEC;
          w_pend_nxt     = '0;
          w_pend_vld_nxt = 1'b0;
          w_state_nxt    = TRAPPED;
        end else begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (trap || w_misaligned) begin
          w_pc_nxt       = TRAP_VEC;
          w_pend_nxt     = '0;
          w_pend_vld_nxt = 1'b0;
          w_state_nxt    = TRAPPED;
          w_misalign_nxt = ~trap;
        end else if (w_advance && r_pend_vld) begin
          // The current pc_sel belongs to the flushed instruction.
          w_pc_nxt       = r_pend;
          w_pend_vld_nxt = 1'b0;
        end else if (w_advance) begin
          w_pc_nxt = w_target;
        end else if (w_redirect && !r_pend_vld) begin
          w_pend_nxt     = w_target;
          w_pend_vld_nxt = 1'b1;
        end
      end
      default: w_state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= BOOT;
      r_pc       <= RESET_VEC;
      r_pend     <= '0;
      r_pend_vld <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_pend     <= w_pend_nxt;
      r_pend_vld <= w_pend_vld_nxt;
      r_misalign <= w_misalign_nxt;
    end
  end

  assign imem_req      = (r_state == RUN);
  assign pc_out        = r_pc;
  assign pc_plus4      = w_seq;
  assign misalign_exc  = r_misalign;
  assign redir_pending = r_pend_vld;

endmodule
